flash_ctrl: RTL and testbench

FLASH_CTRL -- requirements
Module: flash_ctrl

---
 rtl/flash_ctrl_pkg.sv | 26 ++
 rtl/flash_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_flash_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl_pkg: shared FSM state encoding, NOR flash command words and status-register bit positions.
package flash_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RD,
        S_PG_CMD,
        S_PG_DATA,
        S_POLL,
        S_FIN
    } state_t;

    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;
    localparam logic [15:0] CMD_PROGRAM    = 16'h0040;

    localparam int SR_READY    = 7;
    localparam int SR_PRG_ERR  = 4;
    localparam int SR_VPP_ERR  = 3;
    localparam int SR_LOCK_ERR = 1;

    function automatic logic status_failed(input logic [15:0] sr);
        return sr[SR_PRG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
    endfunction

endpackage

// File: rtl/flash_ctrl.sv
// flash_ctrl: word read / word program controller for an asynchronous NOR flash.
// Defining FLASH_PROGRAM_EN adds the program path (PG_CMD, PG_DATA, POLL) and drives vpen high.
module flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int WAIT_CYC = 4,
    parameter int POLL_MAX = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [21:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [22:0] flash_addr,
    inout  wire  [15:0] flash_data,
    output logic        flash_byte,
    output logic        flash_vpen,
    output logic        flash_ce,
    output logic        flash_oe,
    output logic        flash_we,
    output logic        flash_rp
);

    state_t      state;
    logic [3:0]  cnt;
    logic        rec;
    logic        last;
    logic        array_mode;
    logic        data_oe;
    logic [15:0] data_out;
    logic [21:0] addr_q;

    assign last       = cnt == 4'(WAIT_CYC - 1);
    assign flash_byte = 1'b1;
    assign flash_addr = {addr_q, 1'b0};
    assign flash_data = data_oe ? data_out : 16'bz;

`ifdef FLASH_PROGRAM_EN
    localparam int PW = POLL_MAX > 1 ? $clog2(POLL_MAX) : 1;
    logic [15:0]   wdata_q;
    logic [PW-1:0] poll_cnt;
`else
    localparam int unused_poll_max = POLL_MAX;
    logic unused_wr;
    assign unused_wr  = ^{wr_req, wdata};
    assign flash_vpen = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rec        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            array_mode <= 1'b0;
            data_oe    <= 1'b0;
            data_out   <= '0;
            addr_q     <= '0;
            flash_ce   <= 1'b1;
            flash_oe   <= 1'b1;
            flash_we   <= 1'b1;
            flash_rp   <= 1'b0;
`ifdef FLASH_PROGRAM_EN
            err        <= 1'b0;
            flash_vpen <= 1'b0;
            wdata_q    <= '0;
            poll_cnt   <= '0;
`endif
        end else begin
            flash_rp <= 1'b1;
            done     <= 1'b0;
`ifdef FLASH_PROGRAM_EN
            flash_vpen <= 1'b1;
            err        <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        addr_q   <= addr;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        rec      <= 1'b0;
                        flash_ce <= 1'b0;
                        if (array_mode) begin
                            state    <= S_RD;
                            flash_oe <= 1'b0;
                        end else begin
                            state    <= S_CMD;
                            flash_we <= 1'b0;
                            data_oe  <= 1'b1;
                            data_out <= CMD_READ_ARRAY;
                        end
                    end
`ifdef FLASH_PROGRAM_EN
                    else if (wr_req) begin
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        rec      <= 1'b0;
                        state    <= S_PG_CMD;
                        flash_ce <= 1'b0;
                        flash_we <= 1'b0;
                        data_oe  <= 1'b1;
                        data_out <= CMD_PROGRAM;
                    end
`endif
                end
                S_CMD: begin
                    if (!rec) begin
                        if (last) begin
                            rec      <= 1'b1;
                            flash_ce <= 1'b1;
                            flash_we <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        rec        <= 1'b0;
                        cnt        <= '0;
                        state      <= S_RD;
                        array_mode <= 1'b1;
                        data_oe    <= 1'b0;
                        flash_ce   <= 1'b0;
                        flash_oe   <= 1'b0;
                    end
                end
                S_RD: begin
                    if (last) begin
                        rdata    <= flash_data;
                        flash_ce <= 1'b1;
                        flash_oe <= 1'b1;
                        state    <= S_FIN;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
`ifdef FLASH_PROGRAM_EN
                S_PG_CMD, S_PG_DATA: begin
                    if (!rec) begin
                        if (last) begin
                            rec      <= 1'b1;
                            flash_ce <= 1'b1;
                            flash_we <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        rec      <= 1'b0;
                        cnt      <= '0;
                        flash_ce <= 1'b0;
                        if (state == S_PG_CMD) begin
                            state    <= S_PG_DATA;
                            data_out <= wdata_q;
                            flash_we <= 1'b0;
                        end else begin
                            // the device leaves read-array mode once programming starts
                            state      <= S_POLL;
                            array_mode <= 1'b0;
                            data_oe    <= 1'b0;
                            flash_oe   <= 1'b0;
                            poll_cnt   <= '0;
                        end
                    end
                end
                S_POLL: begin
                    if (!rec) begin
                        if (last) begin
                            flash_ce <= 1'b1;
                            flash_oe <= 1'b1;
                            if (flash_data[SR_READY]) begin
                                state <= S_FIN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                err   <= status_failed(flash_data);
                            end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                                state <= S_FIN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end else begin
                                rec      <= 1'b1;
                                poll_cnt <= poll_cnt + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        // one idle cycle between status reads so each read is a fresh oe strobe
                        rec      <= 1'b0;
                        cnt      <= '0;
                        flash_ce <= 1'b0;
                        flash_oe <= 1'b0;
                    end
                end
`endif
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: table-driven bench for flash_ctrl with a behavioural NOR flash model.
// Program-path vectors are included only when FLASH_PROGRAM_EN is defined.
module tb_flash_ctrl;

    localparam int W  = 4;
    localparam int PM = 8;
`ifdef FLASH_PROGRAM_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [21:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        busy, done, err;
    logic [22:0] flash_addr;
    wire  [15:0] flash_data;
    logic        flash_byte, flash_vpen, flash_ce, flash_oe, flash_we, flash_rp;

    flash_ctrl #(.WAIT_CYC(W), .POLL_MAX(PM)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .err(err), .flash_addr(flash_addr),
        .flash_data(flash_data), .flash_byte(flash_byte), .flash_vpen(flash_vpen),
        .flash_ce(flash_ce), .flash_oe(flash_oe), .flash_we(flash_we), .flash_rp(flash_rp)
    );

    always #5 clk = ~clk;

    // behavioural flash: array reads, 0x00FF / 0x0040 commands, status with a busy countdown
    logic [15:0] mem [int];
    logic [15:0] wr_log [$];
    logic [15:0] rd_val = '0;
    logic [15:0] final_status = 16'h0080;
    bit          status_mode = 0, prog_pending = 0, overlap = 0, contention = 0;
    int          busy_left = 0, busy_cfg = 0, status_reads = 0;

    function automatic logic [15:0] word_at(input int a);
        return mem.exists(a) ? mem[a] : (16'(a) ^ 16'hA5A5);
    endfunction

    assign flash_data = (!flash_ce && !flash_oe) ? rd_val : 16'bz;

    always @(negedge clk) begin
        rd_val <= status_mode ? (busy_left > 0 ? 16'h0000 : final_status) : word_at(int'(flash_addr[22:1]));
        if (!flash_oe && !flash_we) overlap <= 1;
        if (!flash_oe && !flash_ce && $isunknown(flash_data)) contention <= 1;
    end

    always @(posedge flash_we) begin
        if (rst) begin
            wr_log.push_back(flash_data);
            if (prog_pending) begin
                mem[int'(flash_addr[22:1])] = flash_data;
                prog_pending = 0;
                busy_left = busy_cfg;
                status_mode = 1;
            end else if (flash_data == 16'h0040) begin
                prog_pending = 1;
            end else if (flash_data == 16'h00FF) begin
                status_mode = 0;
            end
        end
    end

    always @(posedge flash_oe) begin
        if (status_mode) begin
            status_reads++;
            if (busy_left > 0) busy_left--;
        end
    end

    always @(negedge flash_rp) begin
        status_mode = 0;
        prog_pending = 0;
        busy_left = 0;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rd, wr;
        logic [21:0] addr;
        logic [15:0] wdata;
        int          polls;
        logic [15:0] fstat;
        bit          exp_done;
        int          exp_nw;
        logic [15:0] exp_w0, exp_w1, exp_rdata;
        bit          exp_err;
        int          exp_reads, exp_lat;
    } vec_t;

    vec_t vecs [$];

    task automatic apply(input vec_t v, input string tag);
        bit got;
        int n;
        logic [22:0] fa;
        logic busy1;
        busy_cfg = v.polls;
        final_status = v.fstat;
        wr_log.delete();
        status_reads = 0;
        rd_req = v.rd;
        wr_req = v.wr;
        addr = v.addr;
        wdata = v.wdata;
        got = 0; n = 0; fa = '0; busy1 = 0;
        while (!got && n < (v.exp_done ? 200 : 40)) begin
            @(posedge clk); #1;
            n++;
            rd_req = 0;
            wr_req = 0;
            if (n == 1) begin fa = flash_addr; busy1 = busy; end
            if (done) got = 1;
        end
        chk({tag, ".done"}, 32'(got), 32'(v.exp_done));
        chk({tag, ".writes"}, wr_log.size(), v.exp_nw);
        if (v.exp_done) begin
            chk({tag, ".latency"}, n, v.exp_lat);
            chk({tag, ".busy"}, 32'(busy1), 1);
            chk({tag, ".flash_addr"}, 32'(fa), 32'({v.addr, 1'b0}));
            chk({tag, ".err"}, 32'(err), 32'(v.exp_err));
            chk({tag, ".status_reads"}, status_reads, v.exp_reads);
            if (v.rd) chk({tag, ".rdata"}, 32'(rdata), 32'(v.exp_rdata));
            if (v.exp_nw > 0) chk({tag, ".w0"}, wr_log.size() > 0 ? 32'(wr_log[0]) : 32'hDEAD, 32'(v.exp_w0));
            if (v.exp_nw > 1) chk({tag, ".w1"}, wr_log.size() > 1 ? 32'(wr_log[1]) : 32'hDEAD, 32'(v.exp_w1));
            @(posedge clk); #1;
            chk({tag, ".done_pulse"}, 32'(done), 0);
            chk({tag, ".busy_after"}, 32'(busy), 0);
        end else begin
            chk({tag, ".idle"}, 32'(busy), 0);
        end
    endtask

    initial begin
        bit got;
        bit saw_done;
        int n;
        mem[32'h10] = 16'hBEEF;

        //             rd wr addr          wdata     polls fstat     done nw w0        w1        rdata     err reads lat
        vecs.push_back('{1, 0, 22'h000010, 16'h0000, 0,    16'h0080, 1,   1, 16'h00FF, 16'h0000, 16'hBEEF, 0,  0,    2*W+2});
        vecs.push_back('{1, 0, 22'h000011, 16'h0000, 0,    16'h0080, 1,   0, 16'h0000, 16'h0000, 16'hA5B4, 0,  0,    W+1});
        vecs.push_back('{1, 0, 22'h3FFFFF, 16'h0000, 0,    16'h0080, 1,   0, 16'h0000, 16'h0000, 16'h5A5A, 0,  0,    W+1});
        vecs.push_back('{1, 1, 22'h000020, 16'h7777, 0,    16'h0080, 1,   0, 16'h0000, 16'h0000, 16'hA585, 0,  0,    W+1});
`ifdef FLASH_PROGRAM_EN
        vecs.push_back('{0, 1, 22'h000100, 16'h1234, 3,    16'h0080, 1,   2, 16'h0040, 16'h1234, 16'h0000, 0,  4,    2*W+2+4*(W+1)});
        vecs.push_back('{1, 0, 22'h000100, 16'h0000, 0,    16'h0080, 1,   1, 16'h00FF, 16'h0000, 16'h1234, 0,  0,    2*W+2});
        vecs.push_back('{0, 1, 22'h000200, 16'hABCD, 0,    16'h0090, 1,   2, 16'h0040, 16'hABCD, 16'h0000, 1,  1,    2*W+2+1*(W+1)});
        vecs.push_back('{0, 1, 22'h000300, 16'h5555, 1000, 16'h0080, 1,   2, 16'h0040, 16'h5555, 16'h0000, 1,  PM,   2*W+2+PM*(W+1)});
        vecs.push_back('{1, 0, 22'h000300, 16'h0000, 0,    16'h0080, 1,   1, 16'h00FF, 16'h0000, 16'h5555, 0,  0,    2*W+2});
`else
        vecs.push_back('{0, 1, 22'h000100, 16'h1234, 0,    16'h0080, 0,   0, 16'h0000, 16'h0000, 16'h0000, 0,  0,    0});
`endif

        // reset state
        @(posedge clk); #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.rdata", 32'(rdata), 0);
        chk("rst.strobes", 32'({flash_ce, flash_oe, flash_we}), 32'h7);
        chk("rst.rp", 32'(flash_rp), 0);
        chk("rst.data_z", 32'(flash_data === 16'bz), 1);
        chk("rst.byte", 32'(flash_byte), 1);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        chk("rp_rise", 32'(flash_rp), 1);
        chk("vpen", 32'(flash_vpen), 32'(PROG));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));
        chk("idle.data_z", 32'(flash_data === 16'bz), 1);

        // requests during busy are dropped, not queued
        wr_log.delete();
        rd_req = 1; addr = 22'h000012; wdata = 16'h9999;
        got = 0; n = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            rd_req = n < 4;
            wr_req = n >= 1 && n < 4;
            if (done) got = 1;
        end
        rd_req = 0; wr_req = 0;
        chk("busy_req.done", 32'(got), 1);
        chk("busy_req.rdata", 32'(rdata), 32'hA5B7);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_req.idle", 32'(busy), 0);
        chk("busy_req.writes", wr_log.size(), 0);

        // reset in the middle of an operation
        wr_log.delete();
        status_reads = 0;
        n = 0;
`ifdef FLASH_PROGRAM_EN
        busy_cfg = 1000;
        wr_req = 1; addr = 22'h000400; wdata = 16'h0BAD;
        while (status_reads < 2 && n < 300) begin
            @(posedge clk); #1;
            n++;
            wr_req = 0;
        end
        chk("midrst.reached_poll", 32'(status_reads >= 2), 1);
`else
        rd_req = 1; addr = 22'h000014;
        repeat (2) begin @(posedge clk); #1; rd_req = 0; end
        chk("midrst.busy", 32'(busy), 1);
`endif
        @(posedge clk); #1;
        rst = 0;
        #1;
        chk("midrst.strobes", 32'({flash_ce, flash_oe, flash_we}), 32'h7);
        chk("midrst.rp", 32'(flash_rp), 0);
        chk("midrst.data_z", 32'(flash_data === 16'bz), 1);
        chk("midrst.busy_low", 32'(busy), 0);
        saw_done = 0;
        repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1; end
        chk("midrst.no_done", 32'(saw_done), 0);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        chk("midrst.rp_rise", 32'(flash_rp), 1);
        apply('{1, 0, 22'h000010, 16'h0000, 0, 16'h0080, 1, 1, 16'h00FF, 16'h0000, 16'hBEEF, 0, 0, 2*W+2}, "after_rst");

        chk("oe_we_overlap", 32'(overlap), 0);
        chk("bus_contention", 32'(contention), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
